// File: rtl/rf_transfer_sequencer_pkg.sv
// Shared codes for the register-file transfer sequencer: request ops, FunSel values,
// register codes and the sequencer FSM states.
package rf_seq_pkg;

    typedef enum logic [2:0] {
        OP_READ  = 3'b000,
        OP_MOVE  = 3'b001,
        OP_LOADI = 3'b010,
        OP_CLEAR = 3'b011,
        OP_INC   = 3'b100,
        OP_DEC   = 3'b101
    } op_e;

    typedef enum logic [2:0] {
        FS_DEC   = 3'b000,
        FS_INC   = 3'b001,
        FS_LOAD  = 3'b010,
        FS_CLEAR = 3'b011
    } fun_sel_e;

    typedef enum logic [2:0] {
        REG_R1, REG_R2, REG_R3, REG_R4,
        REG_S1, REG_S2, REG_S3, REG_S4
    } reg_code_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RD,
        ST_WR,
        ST_DONE
    } state_e;

    function automatic logic op_legal(input logic [2:0] op);
        return op <= OP_DEC;
    endfunction

    // State entered straight after popping a request; illegal ops skip to DONE untouched.
    function automatic state_e dispatch_state(input logic [2:0] op);
        case (op)
            OP_READ, OP_MOVE:                   return ST_RD;
            OP_LOADI, OP_CLEAR, OP_INC, OP_DEC: return ST_WR;
            default:                            return ST_DONE;
        endcase
    endfunction

    function automatic logic [2:0] fun_sel_for(input logic [2:0] op);
        case (op)
            OP_MOVE, OP_LOADI: return FS_LOAD;
            OP_CLEAR:          return FS_CLEAR;
            OP_INC:            return FS_INC;
            default:           return FS_DEC;
        endcase
    endfunction

endpackage

// File: rtl/rf_transfer_sequencer_if.sv
// Request/response handshake between a requester and the transfer sequencer.
// Requests move on req_vld && req_rdy; done is a one-cycle completion pulse.
interface rf_transfer_sequencer_if #(
    parameter int DATA_WIDTH = 32
) ();
    logic                  req_vld;
    logic                  req_rdy;
    logic [2:0]            req_op;
    logic [2:0]            req_dst;
    logic [2:0]            req_src;
    logic [DATA_WIDTH-1:0] req_imm;
    logic                  done;
    logic [DATA_WIDTH-1:0] rsp_dat;
    logic                  rsp_err;

    modport master (
        output req_vld, req_op, req_dst, req_src, req_imm,
        input  req_rdy, done, rsp_dat, rsp_err
    );

    modport slave (
        input  req_vld, req_op, req_dst, req_src, req_imm,
        output req_rdy, done, rsp_dat, rsp_err
    );
endinterface

// File: rtl/rf_transfer_sequencer_req_fifo.sv
// Synchronous request FIFO, registered full/empty; head visible on dat_o while non-empty.
// Pushes when full and pops when empty are ignored.
module rf_req_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] dat_i,
    output logic [WIDTH-1:0] dat_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_push, do_pop;

    // Extra pointer bit tells full from empty when the index bits match.
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign dat_o   = mem_q[rd_ptr_q[AW-1:0]];

    assign do_push  = push_i && !full_o;
    assign do_pop   = pop_i && !empty_o;
    assign wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    assign rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= dat_i;
        end
    end
endmodule

// File: rtl/rf_transfer_sequencer.sv
// Turns queued transfer requests into timed register-file cycles (RD then WR, one Done each).
// Accept-to-Done 3 cycles (MOVE 4, illegal 2); req_rdy low only while the FIFO is full.
module rf_transfer_sequencer
    import rf_seq_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int QUEUE_DEPTH = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    rf_transfer_sequencer_if.slave req_if,
    input  logic [DATA_WIDTH-1:0] rf_out_a_i,
    output logic [DATA_WIDTH-1:0] rf_i_o,
    output logic [3:0]            rf_reg_sel_o,
    output logic [3:0]            rf_scr_sel_o,
    output logic [2:0]            rf_fun_sel_o,
    output logic [2:0]            rf_out_a_sel_o
);
    typedef struct packed {
        logic [2:0]            op;
        logic [2:0]            dst;
        logic [2:0]            src;
        logic [DATA_WIDTH-1:0] imm;
    } req_t;

    req_t   push_dat, head;
    logic   fifo_full, fifo_empty, push, pop;

    state_e                state_q, state_d;
    logic [2:0]            op_q, dst_q, src_q, out_a_sel_q;
    logic [DATA_WIDTH-1:0] imm_q, data_q, rsp_dat_q;

    assign req_if.req_rdy = !fifo_full;
    assign push           = req_if.req_vld && !fifo_full;
    assign push_dat       = '{op: req_if.req_op, dst: req_if.req_dst,
                              src: req_if.req_src, imm: req_if.req_imm};

    rf_req_fifo #(
        .WIDTH ($bits(req_t)),
        .DEPTH (QUEUE_DEPTH)
    ) u_req_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push),
        .pop_i   (pop),
        .dat_i   (push_dat),
        .dat_o   (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_comb begin
        state_d      = state_q;
        pop          = 1'b0;
        rf_reg_sel_o = 4'b0000;
        rf_scr_sel_o = 4'b0000;
        rf_fun_sel_o = FS_DEC;
        rf_i_o       = '0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = dispatch_state(head.op);
                end
            end
            ST_RD: begin
                state_d = (op_q == OP_READ) ? ST_DONE : ST_WR;
            end
            ST_WR: begin
                if (dst_q[2]) begin
                    rf_scr_sel_o = 4'b1000 >> dst_q[1:0];
                end else begin
                    rf_reg_sel_o = 4'b1000 >> dst_q[1:0];
                end
                rf_fun_sel_o = fun_sel_for(op_q);
                if (op_q == OP_MOVE) begin
                    rf_i_o = data_q;
                end else if (op_q == OP_LOADI) begin
                    rf_i_o = imm_q;
                end
                state_d = ST_DONE;
            end
            ST_DONE: begin
                // Chain straight into the next request so back-to-back work has no bubble.
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = dispatch_state(head.op);
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign rf_out_a_sel_o = (state_q == ST_RD) ? src_q : out_a_sel_q;
    assign req_if.done    = (state_q == ST_DONE);
    assign req_if.rsp_err = (state_q == ST_DONE) && !op_legal(op_q);
    assign req_if.rsp_dat = rsp_dat_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            op_q        <= '0;
            dst_q       <= '0;
            src_q       <= '0;
            imm_q       <= '0;
            data_q      <= '0;
            rsp_dat_q   <= '0;
            out_a_sel_q <= '0;
        end else begin
            state_q <= state_d;
            if (pop) begin
                op_q  <= head.op;
                dst_q <= head.dst;
                src_q <= head.src;
                imm_q <= head.imm;
            end
            if (state_q == ST_RD) begin
                data_q      <= rf_out_a_i;
                out_a_sel_q <= src_q;
                if (op_q == OP_READ) begin
                    rsp_dat_q <= rf_out_a_i;
                end
            end
        end
    end
endmodule

// File: tb/tb_rf_transfer_sequencer.sv
// Directed bench: register-file model on the RF side, scoreboard queues for write beats and Done responses.
module tb_rf_transfer_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rf_transfer_sequencer_if #(.DATA_WIDTH(32)) req_if ();

    logic [31:0] rf_out_a, rf_i;
    logic [3:0]  reg_sel, scr_sel;
    logic [2:0]  fun_sel, out_a_sel;

    rf_transfer_sequencer #(
        .DATA_WIDTH  (32),
        .QUEUE_DEPTH (2)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .req_if         (req_if),
        .rf_out_a_i     (rf_out_a),
        .rf_i_o         (rf_i),
        .rf_reg_sel_o   (reg_sel),
        .rf_scr_sel_o   (scr_sel),
        .rf_fun_sel_o   (fun_sel),
        .rf_out_a_sel_o (out_a_sel)
    );

    logic [31:0] rf_mem [8] = '{default: 32'h0};
    assign rf_out_a = rf_mem[out_a_sel];

    typedef struct {
        logic        err;
        logic [31:0] dat;
        int          acc;
        int          lat;
        int          gap;
        string       name;
    } exp_t;

    typedef struct packed {
        logic [3:0]  rs;
        logic [3:0]  ss;
        logic [2:0]  fs;
        logic [31:0] d;
    } wr_t;

    exp_t dq[$];
    wr_t  wq[$];

    int          checks = 0;
    int          fails = 0;
    int          cyc = 0;
    int          last_done = 0;
    int          done_cnt = 0;
    int          base_cnt;
    logic [31:0] last_rd = 32'h0;
    logic        saw_busy = 1'b0;

    logic        pend_vld = 1'b0;
    int          pend_idx = 0;
    logic [2:0]  pend_fs = 3'b0;
    logic [31:0] pend_d = 32'h0;
    wr_t         mon_a, mon_w;
    exp_t        mon_e;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Register-file model: applies the write captured on the previous falling edge.
    always @(posedge clk) begin
        if (pend_vld) begin
            case (pend_fs)
                3'b000:  rf_mem[pend_idx] <= rf_mem[pend_idx] - 32'd1;
                3'b001:  rf_mem[pend_idx] <= rf_mem[pend_idx] + 32'd1;
                3'b010:  rf_mem[pend_idx] <= pend_d;
                default: rf_mem[pend_idx] <= 32'h0;
            endcase
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            pend_vld = 1'b0;
            if (reg_sel != 4'b0 || scr_sel != 4'b0) begin
                mon_a = {reg_sel, scr_sel, fun_sel, rf_i};
                if ($countones({reg_sel, scr_sel}) != 1)
                    chk("one_enable", 64'($countones({reg_sel, scr_sel})), 64'd1);
                if (wq.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL unexpected_write: got %0h expected no write", mon_a);
                end else begin
                    mon_w = wq.pop_front();
                    chk("write_beat", 64'(mon_a), 64'(mon_w));
                end
                for (int i = 0; i < 4; i++) begin
                    if (reg_sel[3-i]) pend_idx = i;
                    if (scr_sel[3-i]) pend_idx = 4 + i;
                end
                pend_fs  = fun_sel;
                pend_d   = rf_i;
                pend_vld = 1'b1;
            end
            if (req_if.done) begin
                done_cnt++;
                if (dq.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL unexpected_done: got done=1 expected 0");
                end else begin
                    mon_e = dq.pop_front();
                    chk({mon_e.name, "_err"}, 64'(req_if.rsp_err), 64'(mon_e.err));
                    chk({mon_e.name, "_dat"}, 64'(req_if.rsp_dat), 64'(mon_e.dat));
                    if (mon_e.lat > 0) chk({mon_e.name, "_lat"}, 64'(cyc - mon_e.acc), 64'(mon_e.lat));
                    if (mon_e.gap > 0) chk({mon_e.name, "_gap"}, 64'(cyc - last_done), 64'(mon_e.gap));
                end
                last_done = cyc;
            end
        end
    end

    task automatic exp_wr(input logic [3:0] rs, input logic [3:0] ss, input logic [2:0] fs, input logic [31:0] d);
        wq.push_back('{rs: rs, ss: ss, fs: fs, d: d});
    endtask

    task automatic send(input logic [2:0] op, input logic [2:0] dst, input logic [2:0] src,
                        input logic [31:0] imm, input string nm, input logic err,
                        input logic [31:0] rd_exp, input int lat, input int gap);
        int   n = 0;
        exp_t e;
        @(negedge clk);
        req_if.req_vld = 1'b1;
        req_if.req_op  = op;
        req_if.req_dst = dst;
        req_if.req_src = src;
        req_if.req_imm = imm;
        while (!req_if.req_rdy && n < 50) begin
            saw_busy = 1'b1;
            @(negedge clk);
            n++;
        end
        if (!req_if.req_rdy) begin
            checks++;
            fails++;
            $display("FAIL %s_accept: got req_rdy=0 expected 1 within 50 cycles", nm);
            req_if.req_vld = 1'b0;
            return;
        end
        if (op == 3'b000) last_rd = rd_exp;
        e.err = err; e.dat = last_rd; e.acc = cyc; e.lat = lat; e.gap = gap; e.name = nm;
        dq.push_back(e);
        @(posedge clk);
        #1 req_if.req_vld = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (dq.size() > 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (dq.size() > 0) begin
            checks++;
            fails++;
            $display("FAIL drain_timeout: got %0d pending expected 0", dq.size());
            dq.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int n;
        req_if.req_vld = 1'b0;
        req_if.req_op  = 3'b0;
        req_if.req_dst = 3'b0;
        req_if.req_src = 3'b0;
        req_if.req_imm = 32'h0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_rdy",      64'(req_if.req_rdy), 64'd1);
        chk("rst_done",     64'(req_if.done),    64'd0);
        chk("rst_err",      64'(req_if.rsp_err), 64'd0);
        chk("rst_rsp_dat",  64'(req_if.rsp_dat), 64'd0);
        chk("rst_enables",  64'({reg_sel, scr_sel}), 64'd0);
        chk("rst_fun_sel",  64'(fun_sel),   64'd0);
        chk("rst_out_asel", 64'(out_a_sel), 64'd0);
        chk("rst_rf_i",     64'(rf_i),      64'd0);

        // LOADI R2, MOVE R2->S3, READ S3
        exp_wr(4'b0100, 4'b0000, 3'b010, 32'hDEADBEEF);
        send(3'b010, 3'd1, 3'd0, 32'hDEADBEEF, "loadi_r2", 1'b0, 32'h0, 3, 0); drain();
        exp_wr(4'b0000, 4'b0010, 3'b010, 32'hDEADBEEF);
        send(3'b001, 3'd6, 3'd1, 32'h0, "move_r2_s3", 1'b0, 32'h0, 4, 0); drain();
        chk("move_out_asel", 64'(out_a_sel), 64'd1);
        send(3'b000, 3'd0, 3'd6, 32'h0, "read_s3", 1'b0, 32'hDEADBEEF, 3, 0); drain();
        chk("read_out_asel", 64'(out_a_sel), 64'd6);

        // Wrap-around and clear are done by the register itself
        exp_wr(4'b0000, 4'b1000, 3'b010, 32'hFFFFFFFF);
        send(3'b010, 3'd4, 3'd0, 32'hFFFFFFFF, "loadi_s1", 1'b0, 32'h0, 3, 0); drain();
        exp_wr(4'b0000, 4'b1000, 3'b001, 32'h0);
        send(3'b100, 3'd4, 3'd0, 32'h0, "inc_s1", 1'b0, 32'h0, 3, 0); drain();
        send(3'b000, 3'd0, 3'd4, 32'h0, "read_s1", 1'b0, 32'h0, 3, 0); drain();
        exp_wr(4'b0001, 4'b0000, 3'b011, 32'h0);
        send(3'b011, 3'd3, 3'd0, 32'h0, "clear_r4", 1'b0, 32'h0, 3, 0); drain();
        send(3'b000, 3'd0, 3'd3, 32'h0, "read_r4_clr", 1'b0, 32'h0, 3, 0); drain();
        exp_wr(4'b0001, 4'b0000, 3'b000, 32'h0);
        send(3'b101, 3'd3, 3'd0, 32'h0, "dec_r4", 1'b0, 32'h0, 3, 0); drain();
        send(3'b000, 3'd0, 3'd3, 32'h0, "read_r4_dec", 1'b0, 32'hFFFFFFFF, 3, 0); drain();

        // Back-to-back burst: FIFO fills, Done pulses two cycles apart
        saw_busy = 1'b0;
        exp_wr(4'b1000, 4'b0000, 3'b010, 32'h11);
        exp_wr(4'b0100, 4'b0000, 3'b010, 32'h22);
        exp_wr(4'b0010, 4'b0000, 3'b010, 32'h33);
        exp_wr(4'b0001, 4'b0000, 3'b010, 32'h44);
        send(3'b010, 3'd0, 3'd0, 32'h11, "burst_a", 1'b0, 32'h0, 3, 0);
        send(3'b010, 3'd1, 3'd0, 32'h22, "burst_b", 1'b0, 32'h0, 0, 2);
        send(3'b010, 3'd2, 3'd0, 32'h33, "burst_c", 1'b0, 32'h0, 0, 2);
        send(3'b010, 3'd3, 3'd0, 32'h44, "burst_d", 1'b0, 32'h0, 0, 2);
        drain();
        chk("burst_backpressure", 64'(saw_busy), 64'd1);

        // Illegal ops and MOVE onto itself
        send(3'b110, 3'd2, 3'd0, 32'h0, "illegal_110", 1'b1, 32'h0, 2, 0); drain();
        send(3'b111, 3'd5, 3'd0, 32'h0, "illegal_111", 1'b1, 32'h0, 2, 0); drain();
        exp_wr(4'b1000, 4'b0000, 3'b010, 32'h11);
        send(3'b001, 3'd0, 3'd0, 32'h0, "move_r1_r1", 1'b0, 32'h0, 4, 0); drain();
        send(3'b000, 3'd0, 3'd0, 32'h0, "read_r1", 1'b0, 32'h11, 3, 0); drain();

        // Reset during WR of MOVE R2->S4 with LOADI R1 queued behind it
        exp_wr(4'b0000, 4'b0001, 3'b010, 32'h22);
        send(3'b001, 3'd7, 3'd1, 32'h0, "move_abort", 1'b0, 32'h0, 0, 0);
        send(3'b010, 3'd0, 3'd0, 32'hAA, "loadi_discard", 1'b0, 32'h0, 0, 0);
        n = 0;
        while (scr_sel == 4'b0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("abort_reached_wr", 64'(scr_sel), 64'b0001);
        rst = 1'b1;
        dq.delete();
        last_rd = 32'h0;
        base_cnt = done_cnt;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_enables", 64'({reg_sel, scr_sel}), 64'd0);
        chk("abort_done",    64'(req_if.done),    64'd0);
        chk("abort_rdy",     64'(req_if.req_rdy), 64'd1);
        chk("abort_rsp_dat", 64'(req_if.rsp_dat), 64'd0);
        repeat (10) @(negedge clk);
        chk("abort_no_done", 64'(done_cnt - base_cnt), 64'd0);
        send(3'b000, 3'd0, 3'd7, 32'h0, "read_s4_post", 1'b0, 32'h22, 3, 0); drain();
        send(3'b000, 3'd0, 3'd0, 32'h0, "read_r1_post", 1'b0, 32'h11, 3, 0); drain();

        chk("writes_drained", 64'(wq.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish expected finish by 500us");
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails + 1);
        $fatal(1);
    end
endmodule
